load_use_scoreboard: RTL and testbench
======================================

// Module: load_use_scoreboard
// PURPOSE
//  Parametrised load-use hazard unit for the core_lapido pipeline. Tracks in-flight loads in
//  a per-register countdown scoreboard and stalls IF/ID (bubble into EX) until loaded data
//  can be forwarded. Supports multi-cycle load latency, memory back-pressure and branch flush.
//  Sits beside the forwarding unit and drives the IF/ID and PC write-enables.
// PARAMETERS
//  NUM_REGS      32  architectural registers; register 0 is hardwired zero, never a hazard
//  REG_ADDR_W     5  register address width, = clog2(NUM_REGS)
//  LOAD_LATENCY   1  cycles after EX before load data is forwardable (>=1; 1 = classic 1 bubble)
//  STALL_CNT_W   16  width of stall statistics counter
// PORTS
//  clk              in   1           core clock, rising edge
//  rst_n            in   1           asynchronous, active-low reset
//  mem_ready        in   1           1 = pipeline advances this cycle; 0 = global memory stall
//  flush            in   1           branch taken: instruction in ID is being killed
//  ex_valid         in   1           ID/EX holds a real instruction
//  ex_is_load       in   1           ID/EX instruction is a load
//  ex_reg_write     in   1           ID/EX instruction writes a register
//  ex_rd            in   REG_ADDR_W  ID/EX destination register
//  id_valid         in   1           IF/ID holds a real instruction
//  id_rs, id_rt     in   REG_ADDR_W  IF/ID source registers
//  id_uses_rs/_rt   in   1           IF/ID instruction actually reads rs / rt
//  stall_pipeline   out  1           hold PC and IF/ID, insert bubble into ID/EX
//  hazard_rs/_rt    out  1           per-source hazard flags (debug/forwarding qualifiers)
//  stall_cycles     out  STALL_CNT_W saturating count of cycles with stall_pipeline & mem_ready
// BEHAVIOUR
//  - Scoreboard: cnt[r], r=1..NUM_REGS-1, width clog2(LOAD_LATENCY+1); reset all 0 asynchronously.
//  - ex_load = ex_valid & ex_is_load & ex_reg_write & (ex_rd != 0).
//  - src hazard (rs shown, rt identical): hazard_rs = id_valid & ~flush & id_uses_rs &
//    (id_rs != 0) & ((ex_load & ex_rd == id_rs) | (cnt[id_rs] != 0)). Combinational, 0 latency.
//  - stall_pipeline = hazard_rs | hazard_rt. Combinational; 0 whenever id_valid=0 or flush=1.
//  - Update on rising clk only when mem_ready=1 (mem_ready=0 freezes all state):
//      * every nonzero cnt[r] decrements by 1;
//      * if ex_load: cnt[ex_rd] <= LOAD_LATENCY-1 (load load overrides decrement);
//      * else if ex_valid & ex_reg_write & ex_rd != 0: cnt[ex_rd] <= 0 (newer ALU write
//        supersedes pending load, WAW; value forwarded from EX).
//  - Result: dependent instruction directly behind a load sees exactly LOAD_LATENCY bubbles;
//    at distance d (d-1 independent instrs between) sees max(0, LOAD_LATENCY-d+1) bubbles.
//  - Stall does not block EX: the load still advances and the scoreboard still updates.
//  - flush: suppresses hazard for killed ID instruction; pending cnt[] untouched (loads in
//    MEM still complete).
//  - stall_cycles: increments when stall_pipeline & mem_ready; saturates at all-ones; reset 0.
//  - Reset mid-operation: all cnt[] and stall_cycles to 0 immediately, stall_pipeline follows
//    inputs only (ex_load match still stalls).
//  - ex_rd == 0 or id_rs/id_rt == 0: never creates or reports a hazard.
// STRUCTURE
//  - Shared header lapido_defines.vh: REG_ZERO (5'd0), default LOAD_LATENCY, REG_ADDR_W.
//  - One sub-module: load_pending_counter (one scoreboard entry: set/clear/decrement/busy),
//    generate-instantiated NUM_REGS-1 times; read muxes and stall logic in top.
// TESTING
//  - LATENCY=1: lw r5 in EX, add r6,r5,r7 in ID -> stall 1 cycle, then 0; stall_cycles=1.
//  - LATENCY=3: lw r5 then dependent -> 3 stall cycles; with 1 independent between -> 2.
//  - LATENCY=2: lw r5, stall asserted; mem_ready=0 for 4 cycles -> stall held, cnt frozen,
//    stall_cycles unchanged; then resumes, total 2 counted stall cycles.
//  - lw r0 or consumer reading r0; id_uses_rt=0 with id_rt=r5 -> no stall.
//  - LATENCY=3: lw r5 then add r5 (ALU write) in EX -> cnt[5] cleared; reader of r5 no stall.
//  - flush=1 during hazard -> stall 0 that cycle; rst_n low mid-stall -> cnt cleared, counter 0.

Source files
------------

// File: rtl/load_use_scoreboard_pkg.sv
// Shared constants and helpers for the core_lapido load-use hazard unit.
// Holds the default geometry, the zero-register index and the counter width rule.
package load_use_scoreboard_pkg;

    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_REG_ADDR_W   = 5;
    localparam int DEF_LOAD_LATENCY = 1;
    localparam int DEF_STALL_CNT_W  = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Entry width: enough to hold LOAD_LATENCY-1, never narrower than one bit.
    function automatic int cnt_width(input int load_latency);
        return (load_latency + 1 <= 2) ? 1 : $clog2(load_latency + 1);
    endfunction

endpackage

// File: rtl/load_use_scoreboard_counter.sv
// One scoreboard entry: remaining cycles before a pending load's data is forwardable.
// State only moves when the pipeline advances; set wins over clear, clear over decrement.
module load_pending_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             set,
    input  logic [CNT_W-1:0] set_val,
    input  logic             clear,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (advance) begin
            if (set) begin
                cnt <= set_val;
            end else if (clear) begin
                cnt <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: per-register countdown scoreboard plus the combinational
// stall decision for IF/ID and PC, and a saturating stall-cycle statistic.
module load_use_scoreboard
    import load_use_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int LOAD_LATENCY = DEF_LOAD_LATENCY,
    parameter int STALL_CNT_W  = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_ready,
    input  logic                   flush,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic                   ex_reg_write,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    output logic                   stall_pipeline,
    output logic                   hazard_rs,
    output logic                   hazard_rt,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int                    CNT_W   = cnt_width(LOAD_LATENCY);
    localparam logic [CNT_W-1:0]      SET_VAL = CNT_W'(LOAD_LATENCY - 1);
    localparam logic [REG_ADDR_W-1:0] RZ      = REG_ADDR_W'(REG_ZERO);

    logic                ex_write;
    logic                ex_load;
    logic                ex_alu_write;
    logic [NUM_REGS-1:0] busy;

    assign ex_write     = ex_valid & ex_reg_write & (ex_rd != RZ);
    assign ex_load      = ex_write & ex_is_load;
    assign ex_alu_write = ex_write & ~ex_is_load;

    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        load_pending_counter #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (mem_ready),
            .set     (ex_load && (ex_rd == REG_ADDR_W'(r))),
            .set_val (SET_VAL),
            .clear   (ex_alu_write && (ex_rd == REG_ADDR_W'(r))),
            .busy    (busy[r])
        );
    end

    // The load sitting in EX counts as a hazard on its own; the scoreboard covers the tail.
    assign hazard_rs = id_valid & ~flush & id_uses_rs & (id_rs != RZ) &
                       ((ex_load & (ex_rd == id_rs)) | busy[id_rs]);
    assign hazard_rt = id_valid & ~flush & id_uses_rt & (id_rt != RZ) &
                       ((ex_load & (ex_rd == id_rt)) | busy[id_rt]);

    assign stall_pipeline = hazard_rs | hazard_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_pipeline && mem_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Bench for load_use_scoreboard: three instances (latency 1, 2, 3) share one stimulus
// and are compared every cycle against a timestamp-based model of forwardability.
module tb_load_use_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_ready, flush;
    logic       ex_valid, ex_is_load, ex_reg_write;
    logic [4:0] ex_rd;
    logic       id_valid, id_uses_rs, id_uses_rt;
    logic [4:0] id_rs, id_rt;

    logic        stall [3];
    logic        hz_rs [3];
    logic        hz_rt [3];
    logic [15:0] scnt  [3];

    int errors = 0;
    int checks = 0;

    // Model: a load seen in EX at advance-step s is forwardable once step reaches s+L.
    int ready [3][32];
    int mcnt  [3];
    int step  = 0;

    always #5 clk = ~clk;

    load_use_scoreboard #(.LOAD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .stall_pipeline(stall[0]), .hazard_rs(hz_rs[0]), .hazard_rt(hz_rt[0]), .stall_cycles(scnt[0]));

    load_use_scoreboard #(.LOAD_LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .stall_pipeline(stall[1]), .hazard_rs(hz_rs[1]), .hazard_rt(hz_rt[1]), .stall_cycles(scnt[1]));

    load_use_scoreboard #(.LOAD_LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .stall_pipeline(stall[2]), .hazard_rs(hz_rs[2]), .hazard_rt(hz_rt[2]), .stall_cycles(scnt[2]));

    function automatic bit m_exload();
        return ex_valid && ex_is_load && ex_reg_write && (ex_rd != 0);
    endfunction

    function automatic bit m_hz(input int i, input int src, input bit uses);
        if (!id_valid || flush || !uses || src == 0) return 1'b0;
        return (m_exload() && int'(ex_rd) == src) || (step < ready[i][src]);
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lat%0d: got %0d expected %0d at t=%0t", name, i + 1, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            for (int r = 0; r < 32; r++) ready[i][r] = 0;
        end
    endtask

    task automatic compare_all();
        bit e_rs, e_rt;
        for (int i = 0; i < 3; i++) begin
            e_rs = m_hz(i, int'(id_rs), id_uses_rs);
            e_rt = m_hz(i, int'(id_rt), id_uses_rt);
            chk("hazard_rs", i, int'(hz_rs[i]), int'(e_rs));
            chk("hazard_rt", i, int'(hz_rt[i]), int'(e_rt));
            chk("stall_pipeline", i, int'(stall[i]), int'(e_rs | e_rt));
            chk("stall_cycles", i, int'(scnt[i]), mcnt[i]);
        end
    endtask

    task automatic settle();
        #1;
        if (!rst_n) model_clear();
        compare_all();
    endtask

    // Advance one clock: model applies this cycle's inputs, then back to the falling edge.
    task automatic tick();
        bit st [3];
        @(posedge clk);
        if (rst_n && mem_ready) begin
            for (int i = 0; i < 3; i++) begin
                st[i] = m_hz(i, int'(id_rs), id_uses_rs) | m_hz(i, int'(id_rt), id_uses_rt);
                if (st[i] && mcnt[i] < 65535) mcnt[i]++;
                if (m_exload()) ready[i][ex_rd] = step + i + 1;
                else if (ex_valid && ex_reg_write && ex_rd != 0) ready[i][ex_rd] = 0;
            end
            step++;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit mr, input bit fl, input bit ev, input bit el, input bit ew,
                          input int rd, input bit iv, input int rs, input int rt,
                          input bit urs, input bit urt);
        mem_ready = mr; flush = fl;
        ex_valid = ev; ex_is_load = el; ex_reg_write = ew; ex_rd = 5'(rd);
        id_valid = iv; id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rs = urs; id_uses_rt = urt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("reset_stall", i, int'(stall[i]), 0);
            chk("reset_count", i, int'(scnt[i]), 0);
        end
        tick();
        rst_n = 1'b1;

        // lw r5 then dependent directly behind: L bubbles
        set_in(1, 0, 1, 1, 1, 5, 1, 5, 7, 1, 1); settle();
        chk("A_c0", 0, int'(stall[0]), 1); chk("A_c0", 2, int'(stall[2]), 1);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 5, 7, 1, 1); settle();
        chk("A_c1", 0, int'(stall[0]), 0); chk("A_c1", 1, int'(stall[1]), 1);
        chk("A_c1", 2, int'(stall[2]), 1);
        tick(); settle();
        chk("A_c2", 1, int'(stall[1]), 0); chk("A_c2", 2, int'(stall[2]), 1);
        tick(); settle();
        chk("A_c3", 2, int'(stall[2]), 0);
        chk("A_cnt", 0, int'(scnt[0]), 1); chk("A_cnt", 1, int'(scnt[1]), 2);
        chk("A_cnt", 2, int'(scnt[2]), 3);

        // one independent instruction between: L-1 bubbles
        do_reset();
        set_in(1, 0, 1, 1, 1, 5, 1, 9, 10, 1, 1); settle();
        chk("B_c0", 2, int'(stall[2]), 0);
        tick();
        set_in(1, 0, 1, 0, 1, 11, 1, 7, 5, 1, 1); settle();
        chk("B_c1", 0, int'(stall[0]), 0); chk("B_c1", 2, int'(hz_rt[2]), 1);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 7, 5, 1, 1); settle();
        chk("B_c2", 1, int'(stall[1]), 0); chk("B_c2", 2, int'(stall[2]), 1);
        tick(); settle();
        chk("B_c3", 2, int'(stall[2]), 0); chk("B_cnt", 2, int'(scnt[2]), 2);

        // memory back-pressure freezes scoreboard and statistic
        do_reset();
        set_in(0, 0, 1, 1, 1, 5, 1, 5, 7, 1, 1);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("C_hold", 1, int'(stall[1]), 1); chk("C_hold_cnt", 1, int'(scnt[1]), 0);
            tick();
        end
        mem_ready = 1'b1; settle(); tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 5, 7, 1, 1); settle();
        chk("C_c1", 1, int'(stall[1]), 1);
        tick(); settle();
        chk("C_c2", 1, int'(stall[1]), 0); chk("C_cnt", 1, int'(scnt[1]), 2);

        // zero register and unused source never stall
        do_reset();
        set_in(1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1); settle();
        chk("D_r0", 2, int'(stall[2]), 0);
        tick();
        set_in(1, 0, 1, 1, 1, 5, 1, 6, 5, 1, 0); settle();
        chk("D_unused_rt", 2, int'(stall[2]), 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1); settle();
        chk("D_read_r0", 2, int'(stall[2]), 0);
        tick();

        // ALU write to r5 supersedes pending load
        do_reset();
        set_in(1, 0, 1, 1, 1, 5, 1, 9, 10, 1, 1); settle(); tick();
        set_in(1, 0, 1, 0, 1, 5, 1, 9, 10, 1, 1); settle(); tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 5, 5, 1, 1); settle();
        chk("E_waw", 2, int'(stall[2]), 0); chk("E_waw", 1, int'(stall[1]), 0);
        tick();

        // flush masks the hazard but keeps the pending load; reset clears it
        do_reset();
        set_in(1, 1, 1, 1, 1, 5, 1, 5, 7, 1, 1); settle();
        chk("F_flush", 0, int'(stall[0]), 0); chk("F_flush", 2, int'(hz_rs[2]), 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 1, 5, 7, 1, 1); settle();
        chk("F_after", 2, int'(stall[2]), 1); chk("F_after", 0, int'(stall[0]), 0);
        tick();
        rst_n = 1'b0; settle();
        chk("F_rst_stall", 2, int'(stall[2]), 0); chk("F_rst_cnt", 2, int'(scnt[2]), 0);
        set_in(1, 0, 1, 1, 1, 5, 1, 5, 7, 1, 1); settle();
        chk("F_rst_exload", 0, int'(stall[0]), 1);
        tick();
        rst_n = 1'b1;

        // randomized traffic on a small register window
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            set_in($urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 5) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom));
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
